// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem request/response handshake and IF/ID register.
// Optional macro STALL_CNT_EN adds the StallCnt_o hazard-stall counter output.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Hazard_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        IF_IDvalid_o,
  output logic [31:0] IF_IDpc_o,
  output logic [31:0] IF_IDinst_o,
  output logic [4:0]  IF_IDrs1_o,
  output logic [4:0]  IF_IDrs2_o
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] StallCnt_o
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, KILL, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic        pc_inc;
  logic        load_resp;
  logic        load_buf;
  logic        buf_wr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_inc    = 1'b0;
    load_resp = 1'b0;
    load_buf  = 1'b0;
    buf_wr    = 1'b0;
    case (state_q)
      FETCH: begin
        if (Branch_i) begin
          if (imem_gnt_i) state_d = KILL;
        end else if (imem_gnt_i) begin
          state_d = WAIT;
          pc_inc  = 1'b1;
        end
      end
      WAIT: begin
        if (Branch_i) begin
          state_d = imem_rvalid_i ? FETCH : KILL;
        end else if (imem_rvalid_i && !Hazard_i) begin
          load_resp = 1'b1;
          state_d   = FETCH;
        end else if (imem_rvalid_i) begin
          buf_wr  = 1'b1;
          state_d = HOLD;
        end
      end
      KILL: begin
        if (imem_rvalid_i) state_d = FETCH;
      end
      HOLD: begin
        if (Branch_i) begin
          state_d = FETCH;
        end else if (!Hazard_i) begin
          load_buf = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Request is suppressed during reset even though state already reads FETCH.
  always_comb begin
    imem_req_o  = (state_q == FETCH) && !rst_i;
    imem_addr_o = pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= NOP_INST;
    end else begin
      if (Branch_i) begin
        pc_q <= BranchTarget_i;
      end else if (pc_inc) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end
      if (buf_wr) begin
        buf_pc_q   <= req_pc_q;
        buf_inst_q <= imem_rdata_i;
      end
    end
  end

  // Branch beats stall; a stall freezes IF/ID; otherwise load or insert a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      IF_IDvalid_o <= 1'b0;
      IF_IDpc_o    <= '0;
      IF_IDinst_o  <= NOP_INST;
    end else if (Branch_i) begin
      IF_IDvalid_o <= 1'b0;
      IF_IDinst_o  <= NOP_INST;
    end else if (Hazard_i) begin
      IF_IDvalid_o <= IF_IDvalid_o;
    end else if (load_resp) begin
      IF_IDvalid_o <= 1'b1;
      IF_IDpc_o    <= req_pc_q;
      IF_IDinst_o  <= imem_rdata_i;
    end else if (load_buf) begin
      IF_IDvalid_o <= 1'b1;
      IF_IDpc_o    <= buf_pc_q;
      IF_IDinst_o  <= buf_inst_q;
    end else begin
      IF_IDvalid_o <= 1'b0;
      IF_IDinst_o  <= NOP_INST;
    end
  end

  assign IF_IDrs1_o = IF_IDinst_o[19:15];
  assign IF_IDrs2_o = IF_IDinst_o[24:20];

`ifdef STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      StallCnt_o <= '0;
    else if (Hazard_i && !Branch_i) StallCnt_o <= StallCnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scripted-cycle bench for if_fetch_stage; accepted responses are scoreboarded
// and compared against IF/ID when the instruction lands there.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = '0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t sb[$];
  entry_t exp_e;
  int unsigned total = 0;
  int unsigned passed = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INST(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .Hazard_i(hazard), .Branch_i(branch),
    .BranchTarget_i(target), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .IF_IDvalid_o(valid), .IF_IDpc_o(pc), .IF_IDinst_o(inst),
    .IF_IDrs1_o(rs1), .IF_IDrs2_o(rs2)
`ifdef STALL_CNT_EN
    , .StallCnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      exp_e = '{pc: 32'hxxxx_xxxx, inst: 32'hxxxx_xxxx};
      total++;
      $display("FAIL scoreboard_empty got 0 entries exp >=1");
    end else begin
      exp_e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    cyc(); cyc();
    total++; if (req !== 1'b0) $display("FAIL rst_req got %0b exp 0", req); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", valid); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc); else passed++;
    total++; if (inst !== NOP) $display("FAIL rst_inst got %h exp %h", inst, NOP); else passed++;
    total++; if (addr !== 32'h100) $display("FAIL rst_addr got %h exp 100", addr); else passed++;
    rst = 1'b0;
    cyc();
    total++; if (req !== 1'b1) $display("FAIL rel_req got %0b exp 1", req); else passed++;
    total++; if (addr !== 32'h100) $display("FAIL rel_addr got %h exp 100", addr); else passed++;
  endtask

  task automatic test_fetch();
    gnt = 1'b1;
    cyc();
    total++; if (req !== 1'b0) $display("FAIL wait_req got %0b exp 0", req); else passed++;
    rvalid = 1'b1; rdata = 32'h0050_0093;
    sb.push_back('{pc: 32'h100, inst: 32'h0050_0093});
    cyc();
    rvalid = 1'b0; gnt = 1'b0;
    pop_exp();
    total++; if (valid !== 1'b1) $display("FAIL fetch_valid got %0b exp 1", valid); else passed++;
    total++; if (pc !== exp_e.pc) $display("FAIL fetch_pc got %h exp %h", pc, exp_e.pc); else passed++;
    total++; if (inst !== exp_e.inst) $display("FAIL fetch_inst got %h exp %h", inst, exp_e.inst); else passed++;
    total++; if (rs1 !== 5'd0) $display("FAIL fetch_rs1 got %0d exp 0", rs1); else passed++;
    total++; if (rs2 !== 5'd5) $display("FAIL fetch_rs2 got %0d exp 5", rs2); else passed++;
    total++; if (req !== 1'b1) $display("FAIL next_req got %0b exp 1", req); else passed++;
    total++; if (addr !== 32'h104) $display("FAIL next_addr got %h exp 104", addr); else passed++;
    cyc();
    total++; if (valid !== 1'b0) $display("FAIL bubble_valid got %0b exp 0", valid); else passed++;
    total++; if (inst !== NOP) $display("FAIL bubble_inst got %h exp %h", inst, NOP); else passed++;
  endtask

  task automatic test_hazard_hold();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0020_81b3; hazard = 1'b1;
    sb.push_back('{pc: 32'h104, inst: 32'h0020_81b3});
    cyc();
    rvalid = 1'b0;
    total++; if (req !== 1'b0) $display("FAIL hold_req got %0b exp 0", req); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL hold_valid got %0b exp 0", valid); else passed++;
    cyc(); cyc();
    hazard = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL hold_valid3 got %0b exp 0", valid); else passed++;
    cyc();
    pop_exp();
    total++; if (valid !== 1'b1) $display("FAIL unhold_valid got %0b exp 1", valid); else passed++;
    total++; if (pc !== exp_e.pc) $display("FAIL unhold_pc got %h exp %h", pc, exp_e.pc); else passed++;
    total++; if (inst !== exp_e.inst) $display("FAIL unhold_inst got %h exp %h", inst, exp_e.inst); else passed++;
    total++; if (rs1 !== 5'd1 || rs2 !== 5'd2) $display("FAIL unhold_rs got %0d,%0d exp 1,2", rs1, rs2); else passed++;
    total++; if (addr !== 32'h108 || req !== 1'b1) $display("FAIL unhold_addr got %h/%0b exp 108/1", addr, req); else passed++;
    hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (valid !== 1'b1 || pc !== 32'h104) $display("FAIL stall_hold%0d got %0b/%h exp 1/104", i, valid, pc); else passed++;
    end
    hazard = 1'b0;
    cyc();
    total++; if (valid !== 1'b0) $display("FAIL stall_end_valid got %0b exp 0", valid); else passed++;
  endtask

  task automatic test_branch_kill();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; branch = 1'b1; target = 32'h200;
    cyc();
    branch = 1'b0;
    total++; if (req !== 1'b0) $display("FAIL kill_req got %0b exp 0", req); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL kill_valid got %0b exp 0", valid); else passed++;
    cyc();
    total++; if (req !== 1'b0) $display("FAIL kill_req2 got %0b exp 0", req); else passed++;
    rvalid = 1'b1; rdata = 32'hdead_beef;
    cyc();
    rvalid = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL kill_drop got %0b exp 0", valid); else passed++;
    total++; if (req !== 1'b1 || addr !== 32'h200) $display("FAIL kill_redirect got %0b/%h exp 1/200", req, addr); else passed++;
  endtask

  task automatic test_branch_over_hazard();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00c5_8533;
    sb.push_back('{pc: 32'h200, inst: 32'h00c5_8533});
    cyc();
    rvalid = 1'b0;
    pop_exp();
    total++; if (valid !== 1'b1 || inst !== exp_e.inst) $display("FAIL bh_pre got %0b/%h exp 1/%h", valid, inst, exp_e.inst); else passed++;
    branch = 1'b1; hazard = 1'b1; target = 32'h300;
    cyc();
    branch = 1'b0; hazard = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL bh_valid got %0b exp 0", valid); else passed++;
    total++; if (inst !== NOP) $display("FAIL bh_inst got %h exp %h", inst, NOP); else passed++;
    total++; if (pc !== 32'h200) $display("FAIL bh_pc got %h exp 200", pc); else passed++;
    total++; if (req !== 1'b1 || addr !== 32'h300) $display("FAIL bh_addr got %0b/%h exp 1/300", req, addr); else passed++;
  endtask

  task automatic test_wrap();
    branch = 1'b1; target = 32'hFFFF_FFFC;
    cyc();
    branch = 1'b0;
    total++; if (addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pre got %h exp fffffffc", addr); else passed++;
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0073;
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0010_0073});
    cyc();
    rvalid = 1'b0;
    pop_exp();
    total++; if (pc !== exp_e.pc || inst !== exp_e.inst) $display("FAIL wrap_ifid got %h/%h exp %h/%h", pc, inst, exp_e.pc, exp_e.inst); else passed++;
    total++; if (addr !== 32'h0 || req !== 1'b1) $display("FAIL wrap_addr got %h/%0b exp 0/1", addr, req); else passed++;
  endtask

  task automatic test_reset_mid();
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (req !== 1'b0) $display("FAIL mid_req got %0b exp 0", req); else passed++;
    total++; if (addr !== 32'h100) $display("FAIL mid_addr got %h exp 100", addr); else passed++;
    total++; if (valid !== 1'b0 || pc !== 32'h0 || inst !== NOP) $display("FAIL mid_ifid got %0b/%h/%h exp 0/0/%h", valid, pc, inst, NOP); else passed++;
    cyc();
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    cyc();
    rvalid = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL late_rvalid got %0b exp 0", valid); else passed++;
    total++; if (req !== 1'b1 || addr !== 32'h100) $display("FAIL late_state got %0b/%h exp 1/100", req, addr); else passed++;
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt();
    total++; if (stall_cnt !== 32'd0) $display("FAIL cnt_start got %0d exp 0", stall_cnt); else passed++;
    hazard = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch = (i == 2);
      target = 32'h100;
      cyc();
    end
    hazard = 1'b0; branch = 1'b0;
    total++; if (stall_cnt !== 32'd4) $display("FAIL cnt_val got %0d exp 4", stall_cnt); else passed++;
    rst = 1'b1;
    #1;
    total++; if (stall_cnt !== 32'd0) $display("FAIL cnt_rst got %0d exp 0", stall_cnt); else passed++;
    cyc();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_hazard_hold();
    test_branch_kill();
    test_branch_over_hazard();
    test_wrap();
    test_reset_mid();
`ifdef STALL_CNT_EN
    test_stall_cnt();
`endif
    total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d exp 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
